// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle controller that borrows the shared ALU to run
// unsigned 16-bit multiply (shift-and-add) and unsigned divide (restoring,
// compare-then-subtract, two cycles per quotient bit).
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_first,
  output logic [WIDTH-1:0] alu_second,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_zero
);

  typedef enum logic [2:0] {IDLE, MUL, DCMP, DSUB, DONE} state_t;

  localparam logic [3:0]       OP_ADD  = 4'b0000;
  localparam logic [3:0]       OP_SUB  = 4'b0001;
  localparam logic [3:0]       OP_SLTU = 4'b0111;
  localparam logic [3:0]       OP_NONE = 4'b1000;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rs_q;
  logic             ge_q;

  logic [WIDTH-1:0] rs_next;
  logic             carry;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  // Shifted partial remainder; the bit leaving the top of R forces "greater or equal"
  assign carry    = rem[WIDTH-1];
  assign rs_next  = {rem[WIDTH-2:0], dividend[WIDTH-1]};
  assign ge       = carry | ~alu_result[0];
  assign rem_next = ge_q ? alu_result : rs_q;

  // ALU operand/opcode selection, decoded from registered state only
  always_comb begin
    alu_req    = 1'b0;
    alu_first  = '0;
    alu_second = '0;
    alu_op     = OP_NONE;
    case (state)
      MUL: begin
        alu_req    = 1'b1;
        alu_op     = OP_ADD;
        alu_first  = acc;
        alu_second = mplier[0] ? mcand : '0;
      end
      DCMP: begin
        alu_req    = 1'b1;
        alu_op     = OP_SLTU;
        alu_first  = rs_next;
        alu_second = divisor;
      end
      DSUB: begin
        alu_req    = 1'b1;
        alu_op     = OP_SUB;
        alu_first  = rs_q;
        alu_second = divisor;
      end
      default: ;
    endcase
  end

  // Sequencer state, datapath registers and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      rs_q     <= '0;
      ge_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_lo   <= '0;
      res_hi   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mcand    <= src_a;
              mplier   <= src_b;
              dividend <= src_a;
              divisor  <= src_b;
              acc      <= '0;
              rem      <= '0;
              quot     <= '0;
              cnt      <= '0;
              res_lo   <= '0;
              res_hi   <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
              if (!op_div) begin
                state <= MUL;
              end else if (src_b != '0) begin
                state <= DCMP;
              end else begin
                state    <= DONE;
                res_lo   <= '1;
                res_hi   <= src_a;
                div_zero <= 1'b1;
                done     <= 1'b1;
              end
            end
          end
          MUL: begin
            acc    <= alu_result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              res_lo <= alu_result;
              res_hi <= '0;
              done   <= 1'b1;
            end
          end
          DCMP: begin
            rs_q  <= rs_next;
            ge_q  <= ge;
            state <= DSUB;
          end
          DSUB: begin
            rem      <= rem_next;
            quot     <= {quot[WIDTH-2:0], ge_q};
            dividend <= dividend << 1;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              res_lo <= {quot[WIDTH-2:0], ge_q};
              res_hi <= rem_next;
              done   <= 1'b1;
            end else begin
              state <= DCMP;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: drives the sequencer with directed and random MUL/DIVU
// requests, supplies a behavioural ALU, and compares results and latencies
// against plain-arithmetic expectations.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_div;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        flush;
  logic        alu_req;
  logic [15:0] alu_first;
  logic [15:0] alu_second;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        busy;
  logic        done;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        div_zero;

  int testsRun    = 0;
  int testsFailed = 0;

  int          lat;
  int          mulBad;
  int          flushAt;
  int          doneCount;
  logic        sawDone;
  logic [63:0] pulseMask;

  muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_div     (op_div),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .alu_req    (alu_req),
    .alu_first  (alu_first),
    .alu_second (alu_second),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .div_zero   (div_zero)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Shared ALU: add, subtract, set-less-than-unsigned
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      4'b0000: alu_result = alu_first + alu_second;
      4'b0001: alu_result = alu_first - alu_second;
      4'b0111: alu_result = {15'd0, (alu_first < alu_second)};
      default: alu_result = 16'h0000;
    endcase
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue one request and follow it until done, abort, or cycle budget runs out;
  // lat counts edges with the acceptance edge as edge 1
  task automatic applyStimulus(input logic d, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start  = 1'b1;
    op_div = d;
    src_a  = a;
    src_b  = b;
    @(posedge clk);
    #1;
    lat     = 1;
    mulBad  = 0;
    start   = pulseMask[1];
    flush   = (lat == flushAt);
    sawDone = done;
    while (!done && busy && lat < 100) begin
      if (!d && (alu_op !== 4'b0000 || alu_req !== 1'b1)) mulBad++;
      @(posedge clk);
      #1;
      lat++;
      start   = (lat < 64) ? pulseMask[lat] : 1'b0;
      flush   = (lat == flushAt);
      sawDone = sawDone | done;
    end
    if (sawDone) begin
      @(posedge clk);
      #1;
      start = (lat + 1 < 64) ? pulseMask[lat+1] : 1'b0;
      flush = 1'b0;
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  // Run one request and compare against the arithmetic reference
  task automatic runAndCheck(input string name, input logic d, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] expLo;
    logic [15:0] expHi;
    logic        expDz;
    int          expLat;
    logic [15:0] prodFull;
    if (!d) begin
      prodFull = 16'(32'(a) * 32'(b));
      expLo  = prodFull;
      expHi  = 16'h0000;
      expDz  = 1'b0;
      expLat = 17;
    end else if (b == 16'h0000) begin
      expLo  = 16'hFFFF;
      expHi  = a;
      expDz  = 1'b1;
      expLat = 1;
    end else begin
      expLo  = a / b;
      expHi  = a % b;
      expDz  = 1'b0;
      expLat = 33;
    end
    pulseMask = '0;
    flushAt   = -1;
    applyStimulus(d, a, b);
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " res_lo"}, {16'd0, res_lo}, {16'd0, expLo});
    checkOutput({name, " res_hi"}, {16'd0, res_hi}, {16'd0, expHi});
    checkOutput({name, " div_zero"}, {31'd0, div_zero}, {31'd0, expDz});
    checkOutput({name, " busy after done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op_div    = 1'b0;
    src_a     = 16'h0000;
    src_b     = 16'h0000;
    flush     = 1'b0;
    pulseMask = '0;
    flushAt   = -1;

    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset res", {res_hi, res_lo}, 32'd0);
    checkOutput("reset alu_op", {28'd0, alu_op}, 32'h8);
    checkOutput("reset alu_req", {31'd0, alu_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runAndCheck("mul 7x9", 1'b0, 16'd7, 16'd9);
    runAndCheck("mul ffff^2", 1'b0, 16'hFFFF, 16'hFFFF);
    runAndCheck("mul x0", 1'b0, 16'h1234, 16'h0000);
    checkOutput("mul x0 alu ctrl bad cycles", 32'(mulBad), 32'd0);
    runAndCheck("mul 0x1357x0x2468", 1'b0, 16'h1357, 16'h2468);
    checkOutput("mul alu ctrl bad cycles", 32'(mulBad), 32'd0);
    runAndCheck("div 100/7", 1'b1, 16'd100, 16'd7);
    runAndCheck("div ffff/8001", 1'b1, 16'hFFFF, 16'h8001);
    runAndCheck("div 1234/0", 1'b1, 16'd1234, 16'd0);
    runAndCheck("div 10/3", 1'b1, 16'd10, 16'd3);

    // start pulses at cycles 5 and 17 (DONE cycle) must be ignored
    pulseMask     = '0;
    pulseMask[5]  = 1'b1;
    pulseMask[17] = 1'b1;
    flushAt       = -1;
    applyStimulus(1'b0, 16'd300, 16'd5);
    checkOutput("ignored start latency", 32'(lat), 32'd17);
    checkOutput("ignored start res_lo", {16'd0, res_lo}, 32'd1500);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("ignored start extra done", 32'(doneCount), 32'd0);
    checkOutput("ignored start res kept", {16'd0, res_lo}, 32'd1500);
    pulseMask = '0;

    // back-to-back: second request issued in the IDLE cycle after DONE
    runAndCheck("b2b first", 1'b0, 16'd11, 16'd13);
    runAndCheck("b2b second", 1'b1, 16'd200, 16'd9);

    // flush during a divide
    pulseMask = '0;
    flushAt   = 10;
    applyStimulus(1'b1, 16'd5000, 16'd17);
    flushAt   = -1;
    checkOutput("flush saw done", {31'd0, sawDone}, 32'd0);
    checkOutput("flush busy", {31'd0, busy}, 32'd0);
    checkOutput("flush abort edge", 32'(lat), 32'd11);
    checkOutput("flush res", {res_hi, res_lo}, 32'd0);
    checkOutput("flush div_zero", {31'd0, div_zero}, 32'd0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    start  = 1'b1;
    op_div = 1'b0;
    src_a  = 16'd77;
    src_b  = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst alu_op", {28'd0, alu_op}, 32'h8);
    checkOutput("midrst alu_req", {31'd0, alu_req}, 32'd0);
    checkOutput("midrst res", {res_hi, res_lo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runAndCheck("mul after reset", 1'b0, 16'd77, 16'd3);

    // randomized requests against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      logic        rd;
      logic [15:0] ra;
      logic [15:0] rb;
      int          sel;
      rd  = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 16'h0000;
      else if (sel < 4)  rb = 16'($urandom_range(1, 15));
      else               rb = 16'($urandom);
      runAndCheck($sformatf("rand%0d %s 0x%0h,0x%0h", i, rd ? "div" : "mul", ra, rb), rd, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
